// File: rtl/coord_stack_pkg.sv
// Shared widths, default capacity and FSM state type for the coordinate stack arbiter.
package coord_stack_pkg;

  localparam int unsigned COORD_W           = 4;
  localparam int unsigned DEPTH_W           = 6;
  localparam int unsigned DEPTH_MAX_DEFAULT = 63;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapt,
    StDone
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin on a last-grant register, or fixed priority to requester 0
// when ARB_FIXED_PRIO_EN is defined.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       ack_i,
  output logic [1:0] gnt_o
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_fixed;
  assign unused_fixed = ^{clk_i, rst_ni, ack_i};

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0]) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
  end
`else
  // Resets to 1 so requester 0 wins the first contention.
  logic last_q;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else if (ack_i && (req_i != 2'b00)) begin
      last_q <= gnt_o[1];
    end
  end
`endif

endmodule

// File: rtl/coord_stack_arbiter.sv
// Serialises push/pop requests from two requesters onto a single coordinate stack.
// Arbitration policy selected in rr_arb2 by ARB_FIXED_PRIO_EN.
module coord_stack_arbiter
  import coord_stack_pkg::*;
#(
  parameter int unsigned DEPTH_MAX = DEPTH_MAX_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic               op0,
  input  logic               op1,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic               done0,
  output logic               done1,
  output logic               err,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty,
  output logic               sync_err,
  output logic               stk_push,
  output logic               stk_pop,
  output logic [COORD_W-1:0] stk_x,
  output logic [COORD_W-1:0] stk_y,
  input  logic [COORD_W-1:0] stk_xout,
  input  logic [COORD_W-1:0] stk_yout,
  input  logic               stk_fail
);

  localparam logic [DEPTH_W-1:0] DepthMax = DEPTH_W'(DEPTH_MAX);

  state_e             state_q;
  logic               id_q, op_q;
  logic [COORD_W-1:0] x_q, y_q, rd_x_q, rd_y_q;
  logic [DEPTH_W-1:0] depth_q;
  logic               done0_q, done1_q, err_q, sync_err_q, stk_push_q, stk_pop_q;

  logic [1:0]         gnt;
  logic               arb_ack, any_req, win_id, win_op, reject;
  logic [COORD_W-1:0] win_x, win_y;

  rr_arb2 u_arb (
    .clk_i  (clk),
    .rst_ni (rst),
    .req_i  ({req1, req0}),
    .ack_i  (arb_ack),
    .gnt_o  (gnt)
  );

  always_comb begin
    any_req = req0 | req1;
    arb_ack = (state_q == StIdle);
    win_id  = gnt[1];
    win_op  = win_id ? op1 : op0;
    win_x   = win_id ? x1 : x0;
    win_y   = win_id ? y1 : y0;
    reject  = win_op ? (depth_q == DepthMax) : (depth_q == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      id_q       <= 1'b0;
      op_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      depth_q    <= '0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      err_q      <= 1'b0;
      sync_err_q <= 1'b0;
      stk_push_q <= 1'b0;
      stk_pop_q  <= 1'b0;
    end else begin
      stk_push_q <= 1'b0;
      stk_pop_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            id_q <= win_id;
            op_q <= win_op;
            x_q  <= win_x;
            y_q  <= win_y;
            if (reject) begin
              state_q <= StDone;
              err_q   <= 1'b1;
              done0_q <= ~win_id;
              done1_q <= win_id;
            end else begin
              state_q    <= StIssue;
              stk_push_q <= win_op;
              stk_pop_q  <= ~win_op;
            end
          end
        end
        StIssue: state_q <= StCapt;
        StCapt: begin
          state_q <= StDone;
          done0_q <= ~id_q;
          done1_q <= id_q;
          if (stk_fail) begin
            err_q <= 1'b1;
            if (depth_q != '0) begin
              sync_err_q <= 1'b1;
            end
          end else if (op_q) begin
            if (depth_q != DepthMax) begin
              depth_q <= depth_q + 1'b1;
            end
          end else begin
            if (depth_q != '0) begin
              depth_q <= depth_q - 1'b1;
            end
            rd_x_q <= stk_xout;
            rd_y_q <= stk_yout;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          err_q   <= 1'b0;
          rd_x_q  <= '0;
          rd_y_q  <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign done0    = done0_q;
  assign done1    = done1_q;
  assign err      = err_q;
  assign rd_x     = rd_x_q;
  assign rd_y     = rd_y_q;
  assign depth    = depth_q;
  assign full     = (depth_q == DepthMax);
  assign empty    = (depth_q == '0);
  assign sync_err = sync_err_q;
  assign stk_push = stk_push_q;
  assign stk_pop  = stk_pop_q;
  // Data bus is quiet except during the push strobe.
  assign stk_x    = stk_push_q ? x_q : '0;
  assign stk_y    = stk_push_q ? y_q : '0;

endmodule

// File: tb/tb_coord_stack_arbiter.sv
// Directed bench for coord_stack_arbiter with a behavioural stack attached to the strobes.
module tb_coord_stack_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic [3:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic       done0, done1, err, full, empty, sync_err, stk_push, stk_pop;
  logic [3:0] rd_x, rd_y, stk_x, stk_y;
  logic [5:0] depth;
  logic [3:0] stk_xout, stk_yout;
  logic       stk_fail;
  logic       fail_force = 1'b0;

  coord_stack_arbiter #(.DEPTH_MAX(63)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .done0(done0), .done1(done1), .err(err),
    .rd_x(rd_x), .rd_y(rd_y), .depth(depth), .full(full), .empty(empty),
    .sync_err(sync_err), .stk_push(stk_push), .stk_pop(stk_pop), .stk_x(stk_x),
    .stk_y(stk_y), .stk_xout(stk_xout), .stk_yout(stk_yout), .stk_fail(stk_fail)
  );

  always #5 clk = ~clk;

  // Behavioural stack: acts on the edge that ends a strobe cycle.
  logic [3:0] mem_x [0:63];
  logic [3:0] mem_y [0:63];
  int         sp;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp <= 0; stk_xout <= '0; stk_yout <= '0; stk_fail <= 1'b0;
    end else if (stk_push) begin
      mem_x[sp] <= stk_x; mem_y[sp] <= stk_y; sp <= sp + 1; stk_fail <= 1'b0;
    end else if (stk_pop) begin
      if (fail_force || sp == 0) begin
        stk_fail <= 1'b1; stk_xout <= '0; stk_yout <= '0;
      end else begin
        stk_fail <= 1'b0; stk_xout <= mem_x[sp-1]; stk_yout <= mem_y[sp-1]; sp <= sp - 1;
      end
    end
  end

  int         n_push = 0, n_pop = 0;
  logic [3:0] last_sx = '0, last_sy = '0;
  always @(posedge clk) begin
    if (stk_push) begin n_push++; last_sx = stk_x; last_sy = stk_y; end
    if (stk_pop) n_pop++;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int         lat, d_push, d_pop;
  logic       got_id, r_err;
  logic [3:0] r_x, r_y;

  task automatic run_op(input logic r, input logic op, input logic [3:0] x, input logic [3:0] y);
    int p0, q0;
    p0 = n_push; q0 = n_pop; lat = 0;
    if (!r) begin req0 = 1'b1; op0 = op; x0 = x; y0 = y; end
    else    begin req1 = 1'b1; op1 = op; x1 = x; y1 = y; end
    do begin
      @(posedge clk); lat++; @(negedge clk);
    end while (!(done0 || done1) && lat < 20);
    got_id = done1; r_err = err; r_x = rd_x; r_y = rd_y;
    d_push = n_push - p0; d_pop = n_pop - q0;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done0 | done1}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_id;
    repeat (2) @(negedge clk);
    chk("rst_depth", depth, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_done", {done1, done0}, 0);
    chk("rst_err_sync", {err, sync_err}, 0);
    chk("rst_strobes", {stk_push, stk_pop}, 0);
    rst = 1'b1;
    @(negedge clk);

    run_op(1'b1, 1'b0, 4'd0, 4'd0);
    chk("empty_pop_lat", lat, 1);
    chk("empty_pop_err", r_err, 1);
    chk("empty_pop_id", got_id, 1);
    chk("empty_pop_strobe", d_pop, 0);
    chk("empty_pop_depth", depth, 0);

    run_op(1'b0, 1'b1, 4'd3, 4'd5);
    chk("push35_lat", lat, 3);
    chk("push35_err", r_err, 0);
    chk("push35_id", got_id, 0);
    chk("push35_strobes", d_push, 1);
    chk("push35_stk_xy", {last_sx, last_sy}, {4'd3, 4'd5});
    chk("push35_depth", depth, 1);

    run_op(1'b0, 1'b0, 4'd0, 4'd0);
    chk("pop35_rd", {r_x, r_y}, {4'd3, 4'd5});
    chk("pop35_depth", depth, 0);

    run_op(1'b0, 1'b1, 4'd1, 4'd2);
    run_op(1'b0, 1'b1, 4'd4, 4'd7);
    run_op(1'b0, 1'b0, 4'd0, 4'd0);
    chk("pop47_rd", {r_x, r_y}, {4'd4, 4'd7});
    chk("pop47_depth", depth, 1);
    run_op(1'b1, 1'b0, 4'd0, 4'd0);
    chk("pop12_rd", {r_x, r_y}, {4'd1, 4'd2});
    chk("pop12_id", got_id, 1);
    chk("pop12_depth", depth, 0);
    chk("pop12_empty", empty, 1);

    // Both requesters held for four pushes; last grant went to requester 1.
    req0 = 1'b1; req1 = 1'b1; op0 = 1'b1; op1 = 1'b1;
    x0 = 4'd10; y0 = 4'd10; x1 = 4'd11; y1 = 4'd11;
    for (int i = 0; i < 4; i++) begin
      lat = 0;
      do begin
        @(posedge clk); lat++; @(negedge clk);
      end while (!(done0 || done1) && lat < 20);
`ifdef ARB_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = (i % 2 == 1);
`endif
      chk($sformatf("arb_grant%0d", i), {done1, done0}, exp_id ? 2'b10 : 2'b01);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("arb_depth", depth, 4);

    for (int i = 0; i < 59; i++) run_op(1'b0, 1'b1, i[3:0], 4'd6);
    chk("fill_depth", depth, 63);
    chk("fill_full", full, 1);
    chk("fill_empty", empty, 0);
    run_op(1'b0, 1'b1, 4'd9, 4'd9);
    chk("over_lat", lat, 1);
    chk("over_err", r_err, 1);
    chk("over_strobe", d_push, 0);
    chk("over_depth", depth, 63);

    req0 = 1'b1; op0 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b0;
    #1;
    chk("rstcapt_depth", depth, 0);
    chk("rstcapt_flags", {full, empty}, 2'b01);
    chk("rstcapt_outs", {done0, done1, err, stk_push, stk_pop, rd_x, rd_y}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstcapt_nodone", {done0, done1}, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rstcapt_nodone_after", {done0, done1}, 0);
    chk("sync_err_clear", sync_err, 0);

    run_op(1'b0, 1'b1, 4'd2, 4'd3);
    chk("pre_fail_depth", depth, 1);
    fail_force = 1'b1;
    run_op(1'b0, 1'b0, 4'd0, 4'd0);
    fail_force = 1'b0;
    chk("fail_err", r_err, 1);
    chk("fail_rd", {r_x, r_y}, 0);
    chk("fail_depth", depth, 1);
    chk("fail_sync_err", sync_err, 1);
    chk("fail_strobe", d_pop, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
